pipeline_ctrl: RTL and testbench

Centralised hazard, forwarding and memory-wait controller for the 5-stage RISC-V pipeline, replacing the fixed `stall_if` / `id_stall_i(1'b0)` tie-offs. It produces per-stage stall and flush/bubble controls plus EX operand-forwarding selects. It adds variable-latency IMEM and DMEM support: an ack-based DMEM handshake with a timeout, and an IMEM-not-ready bubble. Register-address width and the DMEM timeout are parameters.

---
 rtl/pipeline_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and memory-wait controller for the 5-stage pipeline.
// Optional performance counters are enabled with `define PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned DMEM_TIMEOUT = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] ID_rs1_i,
    input  logic [REG_ADDR_W-1:0] ID_rs2_i,
    input  logic                  ID_uses_rs1_i,
    input  logic                  ID_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] EX_rs1_i,
    input  logic [REG_ADDR_W-1:0] EX_rs2_i,
    input  logic [REG_ADDR_W-1:0] EX_rd_i,
    input  logic                  EX_write_reg_i,
    input  logic                  EX_read_mem_i,
    input  logic                  EX_redirect_i,
    input  logic [REG_ADDR_W-1:0] MEM_rd_i,
    input  logic                  MEM_write_reg_i,
    input  logic                  MEM_read_mem_i,
    input  logic                  MEM_write_mem_i,
    input  logic [REG_ADDR_W-1:0] WB_rd_i,
    input  logic                  WB_write_reg_i,
    input  logic                  IMEM_ready_i,
    input  logic                  DMEM_ack_i,
    output logic                  DMEM_req_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  stall_ex_o,
    output logic                  stall_mem_o,
    output logic                  flush_if_id_o,
    output logic                  flush_id_ex_o,
    output logic                  bubble_mem_wb_o,
    output logic                  dmem_err_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    localparam int unsigned WCNT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(DMEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR
    } dmem_state_t;

    dmem_state_t       state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              dmem_req, mem_busy, dmem_access;
    logic              load_use, imem_wait;
    logic [1:0]        fwd_a, fwd_b;
    logic              stall_if, stall_id, stall_ex, stall_mem;
    logic              flush_if_id, flush_id_ex, bubble_mem_wb;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
        if (MEM_write_reg_i && MEM_rd_i != '0 && MEM_rd_i == src)
            return 2'b01;
        else if (WB_write_reg_i && WB_rd_i != '0 && WB_rd_i == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(EX_rs1_i);
        fwd_b = fwd_sel(EX_rs2_i);
    end

    assign dmem_access = MEM_read_mem_i | MEM_write_mem_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dmem_req   = 1'b0;
        mem_busy   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dmem_access) begin
                    dmem_req = 1'b1;
                    if (!DMEM_ack_i) begin
                        mem_busy   = 1'b1;
                        state_d    = S_WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                if (DMEM_ack_i) begin
                    state_d = S_IDLE;
                end else begin
                    mem_busy = 1'b1;
                    if (wait_cnt_q == WCNT_LAST)
                        state_d = S_ERR;
                    else
                        wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_ERR: begin
                mem_busy = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign load_use = EX_read_mem_i && EX_write_reg_i && EX_rd_i != '0 &&
                      ((ID_uses_rs1_i && ID_rs1_i == EX_rd_i) ||
                       (ID_uses_rs2_i && ID_rs2_i == EX_rd_i));
    assign imem_wait = !IMEM_ready_i;

    always_comb begin
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        stall_ex      = 1'b0;
        stall_mem     = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        bubble_mem_wb = 1'b0;
        if (mem_busy) begin
            stall_if      = 1'b1;
            stall_id      = 1'b1;
            stall_ex      = 1'b1;
            stall_mem     = 1'b1;
            bubble_mem_wb = 1'b1;
        end else if (EX_redirect_i) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else begin
            if (load_use) begin
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                flush_id_ex = 1'b1;
            end
            // A load-use stall holds IF/ID, so the IMEM bubble must not overwrite it.
            if (imem_wait) begin
                stall_if    = 1'b1;
                flush_if_id = !load_use;
            end
        end
    end

    assign DMEM_req_o      = reset_n & dmem_req;
    assign fwd_a_o         = reset_n ? fwd_a : 2'b00;
    assign fwd_b_o         = reset_n ? fwd_b : 2'b00;
    assign stall_if_o      = reset_n & stall_if;
    assign stall_id_o      = reset_n & stall_id;
    assign stall_ex_o      = reset_n & stall_ex;
    assign stall_mem_o     = reset_n & stall_mem;
    assign flush_if_id_o   = reset_n & flush_if_id;
    assign flush_id_ex_o   = reset_n & flush_id_ex;
    assign bubble_mem_wb_o = reset_n & bubble_mem_wb;
    assign dmem_err_o      = reset_n & (state_q == S_ERR);

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_if && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (EX_redirect_i && !mem_busy && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl, built with DMEM_TIMEOUT=4.
module tb_pipeline_ctrl;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 32;

    localparam logic [3:0] ST_NONE = 4'b0000;
    localparam logic [3:0] ST_ALL  = 4'b1111;
    localparam logic [3:0] ST_LU   = 4'b1100;
    localparam logic [3:0] ST_IF   = 4'b1000;
    localparam logic [2:0] FL_NONE = 3'b000;
    localparam logic [2:0] FL_BUB  = 3'b001;
    localparam logic [2:0] FL_LU   = 3'b010;
    localparam logic [2:0] FL_RED  = 3'b110;
    localparam logic [2:0] FL_IMEM = 3'b100;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [RW-1:0] ID_rs1_i, ID_rs2_i, EX_rs1_i, EX_rs2_i, EX_rd_i, MEM_rd_i, WB_rd_i;
    logic          ID_uses_rs1_i, ID_uses_rs2_i, EX_write_reg_i, EX_read_mem_i, EX_redirect_i;
    logic          MEM_write_reg_i, MEM_read_mem_i, MEM_write_mem_i, WB_write_reg_i;
    logic          IMEM_ready_i, DMEM_ack_i;
    logic          DMEM_req_o, dmem_err_o;
    logic [1:0]    fwd_a_o, fwd_b_o;
    logic          stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
    logic          flush_if_id_o, flush_id_ex_o, bubble_mem_wb_o;
    logic [CW-1:0] stall_cycles_o, flush_count_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned stall_ref = 0;
    int unsigned flush_ref = 0;
    logic [12:0] exp_q[$];

    pipeline_ctrl #(.REG_ADDR_W(RW), .DMEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
        .ID_uses_rs1_i(ID_uses_rs1_i), .ID_uses_rs2_i(ID_uses_rs2_i),
        .EX_rs1_i(EX_rs1_i), .EX_rs2_i(EX_rs2_i), .EX_rd_i(EX_rd_i),
        .EX_write_reg_i(EX_write_reg_i), .EX_read_mem_i(EX_read_mem_i),
        .EX_redirect_i(EX_redirect_i),
        .MEM_rd_i(MEM_rd_i), .MEM_write_reg_i(MEM_write_reg_i),
        .MEM_read_mem_i(MEM_read_mem_i), .MEM_write_mem_i(MEM_write_mem_i),
        .WB_rd_i(WB_rd_i), .WB_write_reg_i(WB_write_reg_i),
        .IMEM_ready_i(IMEM_ready_i), .DMEM_ack_i(DMEM_ack_i),
        .DMEM_req_o(DMEM_req_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
        .stall_ex_o(stall_ex_o), .stall_mem_o(stall_mem_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
        .bubble_mem_wb_o(bubble_mem_wb_o), .dmem_err_o(dmem_err_o),
        .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {req, err, fwd_a, fwd_b, stall if/id/ex/mem, flush if_id/id_ex, bubble}
    function automatic logic [12:0] mk(input logic req, input logic err, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic [3:0] st, input logic [2:0] fl);
        return {req, err, fa, fb, st, fl};
    endfunction

    function automatic logic [12:0] got_vec();
        return {DMEM_req_o, dmem_err_o, fwd_a_o, fwd_b_o, stall_if_o, stall_id_o,
                stall_ex_o, stall_mem_o, flush_if_id_o, flush_id_ex_o, bubble_mem_wb_o};
    endfunction

    function automatic logic [1:0] fwd_ref(input logic [RW-1:0] rs);
        if (MEM_write_reg_i && MEM_rd_i != 0 && MEM_rd_i == rs) return 2'b01;
        if (WB_write_reg_i && WB_rd_i != 0 && WB_rd_i == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic set_idle();
        ID_rs1_i = '0; ID_rs2_i = '0; ID_uses_rs1_i = 1'b0; ID_uses_rs2_i = 1'b0;
        EX_rs1_i = '0; EX_rs2_i = '0; EX_rd_i = '0;
        EX_write_reg_i = 1'b0; EX_read_mem_i = 1'b0; EX_redirect_i = 1'b0;
        MEM_rd_i = '0; MEM_write_reg_i = 1'b0; MEM_read_mem_i = 1'b0; MEM_write_mem_i = 1'b0;
        WB_rd_i = '0; WB_write_reg_i = 1'b0;
        IMEM_ready_i = 1'b1; DMEM_ack_i = 1'b0;
    endtask

    // Inputs are already driven; compare at the falling edge, return just after the next rise.
    task automatic step(input string tag, input logic [12:0] exp);
        logic [12:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq(tag, got_vec(), e);
        if (e[6]) stall_ref++;
        if (EX_redirect_i && e[1]) flush_ref++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
`ifdef PIPELINE_CTRL_PERF_EN
        check_eq({tag, "_stall_cnt"}, stall_cycles_o, stall_ref);
        check_eq({tag, "_flush_cnt"}, flush_count_o, flush_ref);
`else
        check_eq({tag, "_stall_cnt"}, stall_cycles_o, 0);
        check_eq({tag, "_flush_cnt"}, flush_count_o, 0);
`endif
    endtask

    // Called just after a rising edge with inputs left active.
    task automatic reset_pulse(input string tag);
        #1 reset_n = 1'b0;
        #1 check_eq(tag, got_vec(), '0);
        check_eq({tag, "_cnt"}, {stall_cycles_o, flush_count_o}, '0);
        stall_ref = 0;
        flush_ref = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        set_idle();
    endtask

    initial begin
        reset_n = 1'b0;
        set_idle();
        MEM_read_mem_i = 1'b1; IMEM_ready_i = 1'b0; EX_redirect_i = 1'b1;
        MEM_write_reg_i = 1'b1; MEM_rd_i = 5; EX_rs1_i = 5;
        #3 check_eq("reset_outputs", got_vec(), '0);
        check_eq("reset_counters", {stall_cycles_o, flush_count_o}, '0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        set_idle();

        // Forwarding
        MEM_rd_i = 5; MEM_write_reg_i = 1'b1; WB_rd_i = 5; WB_write_reg_i = 1'b1; EX_rs1_i = 5;
        step("fwd_mem_priority", mk(0, 0, 2'b01, 2'b00, ST_NONE, FL_NONE));
        MEM_rd_i = 0; WB_rd_i = 0;
        step("fwd_rd_zero", mk(0, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));
        WB_rd_i = 5;
        step("fwd_wb", mk(0, 0, 2'b10, 2'b00, ST_NONE, FL_NONE));
        MEM_rd_i = 5; MEM_write_reg_i = 1'b0; EX_rs2_i = 5;
        step("fwd_mem_no_write", mk(0, 0, 2'b10, 2'b10, ST_NONE, FL_NONE));
        MEM_write_reg_i = 1'b1;
        step("fwd_both_mem", mk(0, 0, 2'b01, 2'b01, ST_NONE, FL_NONE));
        for (int i = 0; i < 16; i++) begin
            EX_rs1_i = RW'($urandom_range(0, 3)); EX_rs2_i = RW'($urandom_range(0, 3));
            MEM_rd_i = RW'($urandom_range(0, 3)); WB_rd_i = RW'($urandom_range(0, 3));
            MEM_write_reg_i = 1'($urandom_range(0, 1)); WB_write_reg_i = 1'($urandom_range(0, 1));
            step("fwd_random", mk(0, 0, fwd_ref(EX_rs1_i), fwd_ref(EX_rs2_i), ST_NONE, FL_NONE));
        end
        set_idle();

        // Load-use, then the load reaches MEM (zero-wait) and WB
        EX_read_mem_i = 1'b1; EX_write_reg_i = 1'b1; EX_rd_i = 7; ID_uses_rs2_i = 1'b1; ID_rs2_i = 7;
        step("load_use", mk(0, 0, 2'b00, 2'b00, ST_LU, FL_LU));
        EX_read_mem_i = 1'b0; EX_write_reg_i = 1'b0; EX_rd_i = 0;
        MEM_rd_i = 7; MEM_read_mem_i = 1'b1; MEM_write_reg_i = 1'b1; DMEM_ack_i = 1'b1;
        step("load_use_released", mk(1, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));
        set_idle();
        EX_rs2_i = 7; WB_rd_i = 7; WB_write_reg_i = 1'b1;
        step("load_use_fwd_wb", mk(0, 0, 2'b00, 2'b10, ST_NONE, FL_NONE));
        set_idle();
        EX_read_mem_i = 1'b1; EX_write_reg_i = 1'b1; EX_rd_i = 7; ID_rs2_i = 7;
        step("load_use_rs2_unused", mk(0, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));
        EX_rd_i = 0; ID_rs2_i = 0; ID_uses_rs2_i = 1'b1;
        step("load_use_rd_zero", mk(0, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));
        EX_rd_i = 9; ID_uses_rs2_i = 1'b0; ID_uses_rs1_i = 1'b1; ID_rs1_i = 9;
        step("load_use_rs1", mk(0, 0, 2'b00, 2'b00, ST_LU, FL_LU));
        EX_redirect_i = 1'b1; IMEM_ready_i = 1'b0;
        step("redirect_priority", mk(0, 0, 2'b00, 2'b00, ST_NONE, FL_RED));
        set_idle();
        check_counters("after_load_use");

        // IMEM wait for two cycles
        IMEM_ready_i = 1'b0;
        step("imem_wait_0", mk(0, 0, 2'b00, 2'b00, ST_IF, FL_IMEM));
        step("imem_wait_1", mk(0, 0, 2'b00, 2'b00, ST_IF, FL_IMEM));
        set_idle();
        check_counters("after_imem_wait");

        // DMEM read acked three cycles after the request
        MEM_read_mem_i = 1'b1;
        for (int i = 0; i < 3; i++)
            step("dmem_wait", mk(1, 0, 2'b00, 2'b00, ST_ALL, FL_BUB));
        DMEM_ack_i = 1'b1;
        step("dmem_ack", mk(1, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));
        set_idle();
        step("dmem_back_idle", mk(0, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));

        // Redirect held during a DMEM write wait
        MEM_write_mem_i = 1'b1; EX_redirect_i = 1'b1;
        step("redirect_in_wait_0", mk(1, 0, 2'b00, 2'b00, ST_ALL, FL_BUB));
        step("redirect_in_wait_1", mk(1, 0, 2'b00, 2'b00, ST_ALL, FL_BUB));
        DMEM_ack_i = 1'b1;
        step("redirect_on_release", mk(1, 0, 2'b00, 2'b00, ST_NONE, FL_RED));
        set_idle();
        step("redirect_done", mk(0, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));
        check_counters("after_redirect");

        // Ack in the final WAIT cycle still completes
        MEM_read_mem_i = 1'b1;
        for (int i = 0; i < 4; i++)
            step("dmem_late_wait", mk(1, 0, 2'b00, 2'b00, ST_ALL, FL_BUB));
        DMEM_ack_i = 1'b1;
        step("dmem_last_cycle_ack", mk(1, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));
        set_idle();
        step("dmem_late_no_err", mk(0, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));

        // Stray ack in IDLE is ignored
        DMEM_ack_i = 1'b1;
        step("idle_ack_ignored", mk(0, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));
        DMEM_ack_i = 1'b0; MEM_read_mem_i = 1'b1;
        step("idle_still_idle", mk(1, 0, 2'b00, 2'b00, ST_ALL, FL_BUB));

        // Reset in WAIT (the FSM is now in WAIT from the previous step)
        reset_pulse("reset_mid_wait");
        step("after_wait_reset", mk(0, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));

        // Timeout into ERR
        MEM_read_mem_i = 1'b1;
        for (int i = 0; i < 5; i++)
            step("dmem_timeout_wait", mk(1, 0, 2'b00, 2'b00, ST_ALL, FL_BUB));
        step("dmem_err", mk(0, 1, 2'b00, 2'b00, ST_ALL, FL_BUB));
        DMEM_ack_i = 1'b1; EX_redirect_i = 1'b1;
        step("dmem_err_sticky", mk(0, 1, 2'b00, 2'b00, ST_ALL, FL_BUB));
        check_counters("in_err");
        reset_pulse("reset_in_err");
        step("after_err_reset", mk(0, 0, 2'b00, 2'b00, ST_NONE, FL_NONE));
        check_counters("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
